// File: rtl/sw_adder_display_if.sv
// Switch-adder display bus: operands and control in, result, flags and
// active-low seven-segment digits out.
interface sw_adder_display_if #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
);
  logic [WIDTH-1:0]    A;
  logic [WIDTH-1:0]    B;
  logic                CIN;
  logic [1:0]          MODE;
  logic                START;
  logic [WIDTH:0]      SUM;
  logic                OVF;
  logic                BUSY;
  logic                DONE;
  logic [7*DIGITS-1:0] HEX;

  // Switch/button side drives operands and control.
  modport master (
    output A, B, CIN, MODE, START,
    input  SUM, OVF, BUSY, DONE, HEX
  );

  // Adder/display core.
  modport slave (
    input  A, B, CIN, MODE, START,
    output SUM, OVF, BUSY, DONE, HEX
  );
endinterface

// File: rtl/sw_adder_display.sv
// Switch adder with decimal seven-segment readout.
// A START rising edge adds, accumulates or clears the result register, then
// an iterative double-dabble converts the result to BCD one bit per clock;
// the display is refreshed with leading zeros blanked once conversion ends.
module sw_adder_display #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  sw_adder_display_if.slave bus
);

  localparam int SW = WIDTH + 1;          // result width
  localparam int BW = 4 * DIGITS;         // packed BCD width
  localparam int CW = $clog2(SW + 1);     // conversion step counter width
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);
  // Digit 0 shows "0", every higher digit is blank (all segments off).
  localparam logic [7*DIGITS-1:0] HEX_RESET = ~((7*DIGITS)'(7'b0111111));

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  // Active-low gfedcba pattern for one decimal digit; anything else is blank.
  function automatic logic [6:0] f_seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    f_seg7 = 7'b1000000;
      4'd1:    f_seg7 = 7'b1111001;
      4'd2:    f_seg7 = 7'b0100100;
      4'd3:    f_seg7 = 7'b0110000;
      4'd4:    f_seg7 = 7'b0011001;
      4'd5:    f_seg7 = 7'b0010010;
      4'd6:    f_seg7 = 7'b0000010;
      4'd7:    f_seg7 = 7'b1111000;
      4'd8:    f_seg7 = 7'b0000000;
      4'd9:    f_seg7 = 7'b0010000;
      default: f_seg7 = 7'b1111111;
    endcase
  endfunction

  state_t              r_state;
  logic                r_start_q;
  logic [SW-1:0]       r_sum;
  logic                r_ovf;
  logic                r_busy;
  logic                r_done;
  logic [7*DIGITS-1:0] r_hex;
  logic [SW-1:0]       r_bin;    // binary bits still to be shifted into BCD
  logic [BW-1:0]       r_bcd;    // partial BCD result
  logic [CW-1:0]       r_step;   // conversion steps already completed

  logic                w_edge;
  logic [SW-1:0]       w_add_sum;
  logic [SW:0]         w_acc_true;
  logic [BW-1:0]       w_bcd_adj;
  logic [BW+SW-1:0]    w_shift;
  logic [BW-1:0]       w_bcd_next;
  logic [SW-1:0]       w_bin_next;
  logic [7*DIGITS-1:0] w_hex_next;

  assign w_edge = bus.START & ~r_start_q;

  // A + B + CIN always fits in WIDTH+1 bits; the accumulate path keeps one
  // extra bit so the true sum can be tested for overflow.
  assign w_add_sum  = SW'(bus.A) + SW'(bus.B) + SW'(bus.CIN);
  assign w_acc_true = (SW+1)'(r_sum) + (SW+1)'(bus.A) + (SW+1)'(bus.CIN);

  // One double-dabble step: add 3 to every digit >= 5, then shift the
  // BCD/binary pair left by one bit.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition so no latch is inferred.
    w_bcd_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
    w_shift    = {w_bcd_adj, r_bin} << 1;
    w_bcd_next = w_shift[BW+SW-1:SW];
    w_bin_next = w_shift[SW-1:0];
  end

  // Segment encode of the BCD value produced by the current step, blanking
  // zeros above the most significant non-zero digit (digit 0 always shown).
  always_comb begin
    logic lead_zero;
    w_hex_next = '1;
    lead_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (w_bcd_next[4*i +: 4] != 4'd0) begin
        lead_zero = 1'b0;
      end
      if (i == 0 || !lead_zero) begin
        w_hex_next[7*i +: 7] = f_seg7(w_bcd_next[4*i +: 4]);
      end
    end
  end

  // Control FSM: START edge capture, operation, conversion and display update.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state   <= IDLE;
      // START_q comes out of reset high so a button held through reset
      // does not look like a fresh press.
      r_start_q <= 1'b1;
      r_sum     <= '0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hex     <= HEX_RESET;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_step    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_start_q <= bus.START;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            unique case (bus.MODE)
              2'b01: begin
                r_sum <= w_acc_true[SW-1:0];
                r_bin <= w_acc_true[SW-1:0];
                if (w_acc_true[SW]) begin
                  r_ovf <= 1'b1;
                end
              end
              2'b11: begin
                r_sum <= '0;
                r_bin <= '0;
                r_ovf <= 1'b0;
              end
              default: begin
                r_sum <= w_add_sum;
                r_bin <= w_add_sum;
              end
            endcase
            r_bcd   <= '0;
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_state <= CONVERT;
          end
        end
        CONVERT: begin
          r_bcd  <= w_bcd_next;
          r_bin  <= w_bin_next;
          r_step <= r_step + CW'(1);
          if (r_step == LAST_STEP) begin
            r_hex   <= w_hex_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.SUM  = r_sum;
  assign bus.OVF  = r_ovf;
  assign bus.BUSY = r_busy;
  assign bus.DONE = r_done;
  assign bus.HEX  = r_hex;

endmodule

// File: tb/tb_sw_adder_display.sv
// Bench for sw_adder_display (WIDTH=4, DIGITS=2): a constant vector table,
// hand-written multi-cycle sequences and randomized operations compared with
// an arithmetic reference model.
module tb_sw_adder_display;

  localparam int WIDTH  = 4;
  localparam int DIGITS = 2;
  localparam int MODV   = 2 ** (WIDTH + 1);
  localparam logic [13:0] HEX_RST = 14'b1111111_1000000;
  localparam logic [6:0] SEG_LUT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        cin;
    int          exp_sum;
    logic [13:0] exp_hex;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   m_sum;
  bit   m_ovf;
  vec_t vecs [17];

  sw_adder_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  sw_adder_display #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Display a value in decimal: digit i is blank when the value has fewer
  // than i+1 decimal digits, except digit 0.
  function automatic logic [7*DIGITS-1:0] model_hex(input int v);
    int p;
    p = 1;
    model_hex = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == 0 || v >= p) model_hex[7*i +: 7] = SEG_LUT[(v / p) % 10];
      p = p * 10;
    end
  endfunction

  task automatic model_capture(input logic [1:0] m, input logic [3:0] a,
                               input logic [3:0] b, input logic c);
    int t;
    case (m)
      2'b01: begin
        t = m_sum + int'(a) + int'(c);
        if (t >= MODV) m_ovf = 1'b1;
        m_sum = t % MODV;
      end
      2'b11: begin
        m_sum = 0;
        m_ovf = 1'b0;
      end
      default: m_sum = int'(a) + int'(b) + int'(c);
    endcase
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    m_sum = 0;
    m_ovf = 1'b0;
  endtask

  // One full operation: release START for a cycle, press it, then follow
  // the capture, the busy window and the single DONE pulse.
  task automatic run_op(input logic [1:0] m, input logic [3:0] a,
                        input logic [3:0] b, input logic c);
    int win_bad;
    bus.START = 1'b0;
    tick();
    bus.MODE  = m;
    bus.A     = a;
    bus.B     = b;
    bus.CIN   = c;
    bus.START = 1'b1;
    tick();
    model_capture(m, a, b, c);
    check("sum_at_capture", bus.SUM, m_sum);
    check("ovf_at_capture", bus.OVF, m_ovf);
    check("busy_at_capture", bus.BUSY, 1);
    check("done_at_capture", bus.DONE, 0);
    bus.START = 1'b0;
    bus.A     = 4'($urandom);
    bus.B     = 4'($urandom);
    bus.CIN   = 1'($urandom);
    bus.MODE  = 2'($urandom);
    win_bad = 0;
    for (int i = 1; i <= WIDTH; i++) begin
      tick();
      if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) win_bad++;
    end
    check("busy_window_errs", win_bad, 0);
    tick();
    check("done_pulse", bus.DONE, 1);
    check("busy_end", bus.BUSY, 0);
    check("hex", bus.HEX, model_hex(m_sum));
    check("sum_stable", bus.SUM, m_sum);
    check("ovf_stable", bus.OVF, m_ovf);
    tick();
    check("done_one_cycle", bus.DONE, 0);
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_errors = 0;
    m_sum    = 0;
    m_ovf    = 1'b0;
    vecs = '{
      '{2'b00, 4'd9,  4'd7,  1'b1, 17, 14'b1111001_1111000},
      '{2'b10, 4'd0,  4'd0,  1'b0, 0,  14'b1111111_1000000},
      '{2'b00, 4'd0,  4'd0,  1'b1, 1,  14'b1111111_1111001},
      '{2'b00, 4'd1,  4'd0,  1'b1, 2,  14'b1111111_0100100},
      '{2'b00, 4'd2,  4'd1,  1'b0, 3,  14'b1111111_0110000},
      '{2'b10, 4'd4,  4'd0,  1'b0, 4,  14'b1111111_0011001},
      '{2'b00, 4'd3,  4'd2,  1'b0, 5,  14'b1111111_0010010},
      '{2'b00, 4'd2,  4'd4,  1'b0, 6,  14'b1111111_0000010},
      '{2'b00, 4'd3,  4'd4,  1'b0, 7,  14'b1111111_1111000},
      '{2'b00, 4'd4,  4'd4,  1'b0, 8,  14'b1111111_0000000},
      '{2'b00, 4'd5,  4'd4,  1'b0, 9,  14'b1111111_0010000},
      '{2'b10, 4'd8,  4'd2,  1'b0, 10, 14'b1111001_1000000},
      '{2'b00, 4'd7,  4'd7,  1'b0, 14, 14'b1111001_0011001},
      '{2'b00, 4'd12, 4'd13, 1'b1, 26, 14'b0100100_0000010},
      '{2'b11, 4'd3,  4'd3,  1'b1, 0,  14'b1111111_1000000},
      '{2'b10, 4'd15, 4'd15, 1'b0, 30, 14'b0110000_1000000},
      '{2'b00, 4'd15, 4'd15, 1'b1, 31, 14'b0110000_1111001}
    };

    rst       = 1'b1;
    bus.A     = '0;
    bus.B     = '0;
    bus.CIN   = 1'b0;
    bus.MODE  = 2'b00;
    bus.START = 1'b0;

    // Reset state.
    do_reset(2);
    check("rst_sum", bus.SUM, 0);
    check("rst_ovf", bus.OVF, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_hex", bus.HEX, HEX_RST);

    // Constant vector table (add / reserved add / clear).
    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin);
      check("tbl_sum", bus.SUM, vecs[i].exp_sum);
      check("tbl_ovf", bus.OVF, 0);
      check("tbl_hex", bus.HEX, vecs[i].exp_hex);
    end

    // Accumulate wrap from reset: 16, then 0 with OVF, then 16 with OVF kept.
    do_reset(2);
    run_op(2'b01, 4'd15, 4'd0, 1'b1);
    check("acc1_sum", bus.SUM, 16);
    check("acc1_ovf", bus.OVF, 0);
    run_op(2'b01, 4'd15, 4'd0, 1'b1);
    check("acc2_sum", bus.SUM, 0);
    check("acc2_ovf", bus.OVF, 1);
    check("acc2_hex", bus.HEX, HEX_RST);
    run_op(2'b01, 4'd15, 4'd0, 1'b1);
    check("acc3_sum", bus.SUM, 16);
    check("acc3_ovf", bus.OVF, 1);

    // Clear after the wrap.
    run_op(2'b11, 4'd9, 4'd9, 1'b1);
    check("clr_sum", bus.SUM, 0);
    check("clr_ovf", bus.OVF, 0);
    check("clr_hex", bus.HEX, HEX_RST);

    // Held START with an extra press while busy: exactly one operation.
    bus.START = 1'b0;
    tick();
    bus.MODE  = 2'b00;
    bus.A     = 4'd1;
    bus.B     = 4'd2;
    bus.CIN   = 1'b0;
    bus.START = 1'b1;
    tick();
    m_sum = 3;
    bus.A = 4'd7;
    bus.B = 4'd7;
    cnt = 0;
    for (int c = 1; c < 20; c++) begin
      if (c == 2) bus.START = 1'b0;
      if (c == 3) bus.START = 1'b1;
      tick();
      if (bus.DONE === 1'b1) cnt++;
    end
    check("held_done_count", cnt, 1);
    check("held_sum", bus.SUM, 3);
    check("held_busy", bus.BUSY, 0);
    check("held_hex", bus.HEX, model_hex(3));
    bus.START = 1'b0;

    // Reset two edges after a capture aborts the conversion.
    tick();
    bus.MODE  = 2'b00;
    bus.A     = 4'd15;
    bus.B     = 4'd15;
    bus.CIN   = 1'b0;
    bus.START = 1'b1;
    tick();
    check("abort_sum_capture", bus.SUM, 30);
    check("abort_busy_capture", bus.BUSY, 1);
    bus.START = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_sum = 0;
    m_ovf = 1'b0;
    check("abort_sum", bus.SUM, 0);
    check("abort_busy", bus.BUSY, 0);
    check("abort_done", bus.DONE, 0);
    check("abort_hex", bus.HEX, HEX_RST);
    cnt = 0;
    repeat (10) begin
      tick();
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) cnt++;
    end
    check("abort_no_done", cnt, 0);
    check("abort_hex_hold", bus.HEX, HEX_RST);

    // Reset wins over a simultaneous START edge; the held button stays quiet.
    run_op(2'b00, 4'd3, 4'd4, 1'b0);
    bus.START = 1'b0;
    tick();
    bus.MODE  = 2'b00;
    bus.A     = 4'd5;
    bus.B     = 4'd5;
    bus.START = 1'b1;
    rst       = 1'b1;
    tick();
    rst   = 1'b0;
    m_sum = 0;
    m_ovf = 1'b0;
    check("prio_sum", bus.SUM, 0);
    check("prio_busy", bus.BUSY, 0);
    cnt = 0;
    repeat (8) begin
      tick();
      if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) cnt++;
    end
    check("prio_held_quiet", cnt, 0);
    check("prio_sum_hold", bus.SUM, 0);
    bus.START = 1'b0;

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      run_op(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sw_adder_display.md
SW_ADDER_DISPLAY -- requirements
Module: sw_adder_display

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits, legal range 2..16.
REQ-002 Parameter DIGITS, default 2, number of decimal display digits; SHALL satisfy 10^DIGITS > 2^(WIDTH+1)-1.
REQ-003 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 A  in  WIDTH  operand A, unsigned.
REQ-006 B  in  WIDTH  operand B, unsigned.
REQ-007 CIN  in  1  carry-in added to every add/accumulate.
REQ-008 MODE  in  2  00 add, 01 accumulate, 10 add (reserved, identical to 00), 11 clear.
REQ-009 START  in  1  level input (pushbutton/switch); an operation is triggered by its rising edge only.
REQ-010 SUM  out  WIDTH+1  registered result/accumulator, unsigned.
REQ-011 OVF  out  1  sticky accumulate-overflow flag.
REQ-012 BUSY  out  1  high while a BCD conversion is in progress.
REQ-013 DONE  out  1  one-cycle pulse when HEX is updated.
REQ-014 HEX  out  7*DIGITS  active-low segments; digit i (0 = least significant) at HEX[7i+6:7i], bit order gfedcba.

Function
REQ-015 Rising edge of START SHALL be detected by registering START; edge = START & ~START_q.
REQ-016 FSM states: IDLE, CONVERT; edge detected in IDLE SHALL perform the operation at that clock edge (capture edge k) and move to CONVERT.
REQ-017 MODE 00/10 at capture: SUM <= A + B + CIN (never exceeds WIDTH+1 bits); OVF unchanged.
REQ-018 MODE 01 at capture: SUM <= (SUM + A + CIN) mod 2^(WIDTH+1); OVF <= 1 if the true sum >= 2^(WIDTH+1), else OVF unchanged.
REQ-019 MODE 11 at capture: SUM <= 0, OVF <= 0; conversion still runs.
REQ-020 CONVERT SHALL run iterative double-dabble on SUM: WIDTH+1 cycles (edges k+1..k+WIDTH+1), each cycle add 3 to every BCD digit >= 5, then shift left one bit.
REQ-021 At edge k+WIDTH+1: HEX updated from BCD result, DONE = 1 for exactly that one cycle, BUSY = 0, state = IDLE.
REQ-022 BUSY SHALL be 1 from edge k through the cycle before DONE asserts.
REQ-023 START edges occurring while BUSY SHALL be ignored (not queued); START_q still tracks START.
REQ-024 SUM, OVF, HEX SHALL be stable between capture/update edges; A, B, CIN, MODE changes outside the capture edge have no effect.
REQ-025 Segment codes (gfedcba, active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank=1111111.
REQ-026 Leading-zero blanking: any digit i>0 that is zero with all higher digits zero SHALL show blank; digit 0 always shows its value.

Reset
REQ-027 RESET = 1 at a clock edge SHALL force, regardless of state: state IDLE, SUM = 0, OVF = 0, BUSY = 0, DONE = 0, START_q = 1 (a held button does not trigger after reset), HEX = digit 0 shows "0", all other digits blank.
REQ-028 RESET during CONVERT SHALL abort conversion; no DONE pulse for the aborted operation.
REQ-029 RESET SHALL take priority over a simultaneous START edge.

Verification (WIDTH=4, DIGITS=2)
REQ-030 Reset: RESET high 2 cycles -> SUM=0, OVF=0, BUSY=0, DONE=0, HEX=1111111_1000000.
REQ-031 Add: MODE=00, A=9, B=7, CIN=1, START 0->1 at edge k -> SUM=17 after edge k, BUSY=1 edges k..k+4, DONE=1 after edge k+5 only, HEX=1111001_1111000 ("17").
REQ-032 Accumulate wrap: from reset, MODE=01, A=15, CIN=1, two START edges -> SUM=16 then SUM=0 with OVF=1, HEX=1111111_1000000; third edge -> SUM=16, OVF stays 1.
REQ-033 Held/busy START: START held high 20 cycles, plus extra 0->1 toggle during BUSY -> exactly one operation, one DONE pulse.
REQ-034 Reset mid-conversion: RESET at edge k+2 after MODE=00, A=15, B=15 capture -> SUM=0, BUSY=0, HEX reset pattern, no DONE within next 10 cycles.
REQ-035 Clear: after REQ-032, MODE=11 START edge -> SUM=0, OVF=0, DONE after 5 more edges, HEX=1111111_1000000.
